// File: rtl/jtag_master_pkg.sv
// Shared definitions for the JTAG master: command encodings, FSM states and
// the TMS walks that take the target from Run-Test/Idle into Shift-IR/Shift-DR.
package jtag_master_pkg;

  typedef enum logic [1:0] {
    CMD_TAP_RESET = 2'b00,
    CMD_SHIFT_IR  = 2'b01,
    CMD_SHIFT_DR  = 2'b10,
    CMD_IDLE      = 2'b11
  } cmd_type_t;

  typedef enum logic [2:0] {
    RESET_SEQ = 3'd0,
    IDLE      = 3'd1,
    PRE       = 3'd2,
    SHIFT     = 3'd3,
    POST      = 3'd4,
    RUN       = 3'd5,
    DONE      = 3'd6
  } state_t;

  // TMS patterns, bit i is the TMS value for PRE TCK i
  localparam logic [3:0] PRE_IR_TMS = 4'b0011;
  localparam logic [5:0] PRE_IR_LEN = 6'd4;
  localparam logic [3:0] PRE_DR_TMS = 4'b0001;
  localparam logic [5:0] PRE_DR_LEN = 6'd3;

  localparam logic [5:0] RESET_TMS1_TCKS = 6'd5;
  localparam logic [5:0] RESET_TCKS      = 6'd6;

  function automatic logic [5:0] shift_len(input logic [5:0] len);
    return (len == 6'd0 || len > 6'd32) ? 6'd32 : len;
  endfunction

  function automatic logic pre_tms_bit(input cmd_type_t t, input logic [1:0] idx);
    logic [3:0] pat;
    pat = (t == CMD_SHIFT_IR) ? PRE_IR_TMS : PRE_DR_TMS;
    return pat[idx];
  endfunction

  function automatic logic [5:0] pre_len_of(input cmd_type_t t);
    return (t == CMD_SHIFT_IR) ? PRE_IR_LEN : PRE_DR_LEN;
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK generator: CLK_DIV clks low then CLK_DIV clks high while enabled, idles low.
// fall_en/rise_en flag the clk edge on which TCK falls/rises.
module jtag_tck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tck,
  output logic fall_en,
  output logic rise_en
);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;
  logic       phase_end;

  assign phase_end = (div_cnt == DIV_LAST);
  assign rise_en   = en && !tck && phase_end;
  assign fall_en   = en && tck && phase_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      tck     <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      tck     <= 1'b0;
    end else if (phase_end) begin
      div_cnt <= '0;
      tck     <= ~tck;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/jtag_master.sv
// JTAG master: runs TAP reset, IR/DR shift and idle-clock commands on the
// TCK/TMS/TDI/TDO pins and returns captured TDO bits for shift commands.
module jtag_master
  import jtag_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [5:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        TCK,
  output logic        TMS,
  output logic        TDI,
  input  logic        TDO,
  output logic        TRST
);
  state_t      state;
  cmd_type_t   cmd_q, cmd_in;
  logic [31:0] data_q, cap_q;
  logic [5:0]  len_q, cnt, cnt_nxt, pre_len;
  logic        tck_en, fall_en, rise_en;

  assign cmd_in    = cmd_type_t'(cmd_type);
  assign cnt_nxt   = cnt + 6'd1;
  assign pre_len   = pre_len_of(cmd_q);
  assign cmd_ready = (state == IDLE);
  assign tck_en    = (state == RESET_SEQ) || (state == PRE) || (state == SHIFT) ||
                     (state == POST) || (state == RUN);

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (tck_en),
    .tck     (TCK),
    .fall_en (fall_en),
    .rise_en (rise_en)
  );

  // TMS/TDI for the next TCK are loaded on the edge where the current TCK falls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RESET_SEQ;
      cmd_q     <= CMD_TAP_RESET;
      data_q    <= '0;
      cap_q     <= '0;
      len_q     <= '0;
      cnt       <= '0;
      TMS       <= 1'b1;
      TDI       <= 1'b0;
      TRST      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          cmd_q  <= cmd_in;
          data_q <= cmd_data;
          cap_q  <= '0;
          cnt    <= '0;
          len_q  <= (cmd_in == CMD_IDLE) ? cmd_len : shift_len(cmd_len);
          case (cmd_in)
            CMD_TAP_RESET: begin
              state <= RESET_SEQ;
              TMS   <= 1'b1;
              TRST  <= 1'b1;
            end
            CMD_SHIFT_IR, CMD_SHIFT_DR: begin
              state <= PRE;
              TMS   <= pre_tms_bit(cmd_in, 2'd0);
            end
            default: begin
              TMS <= 1'b0;
              if (cmd_len != '0) state <= RUN;
            end
          endcase
        end
        RESET_SEQ: if (fall_en) begin
          if (cnt == RESET_TMS1_TCKS - 6'd1) begin
            TMS  <= 1'b0;
            TRST <= 1'b0;
          end
          if (cnt == RESET_TCKS - 6'd1) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        PRE: if (fall_en) begin
          if (cnt == pre_len - 6'd1) begin
            state <= SHIFT;
            cnt   <= '0;
            TMS   <= (len_q == 6'd1);
            TDI   <= data_q[0];
          end else begin
            cnt <= cnt_nxt;
            TMS <= pre_tms_bit(cmd_q, cnt_nxt[1:0]);
          end
        end
        SHIFT: begin
          if (rise_en) cap_q[cnt[4:0]] <= TDO;
          if (fall_en) begin
            if (cnt == len_q - 6'd1) begin
              state <= POST;
              cnt   <= '0;
              TMS   <= 1'b1;
              TDI   <= 1'b0;
            end else begin
              cnt <= cnt_nxt;
              TMS <= (cnt_nxt == len_q - 6'd1);
              TDI <= data_q[cnt_nxt[4:0]];
            end
          end
        end
        POST: if (fall_en) begin
          if (cnt == '0) begin
            cnt <= cnt_nxt;
            TMS <= 1'b0;
          end else begin
            state     <= DONE;
            cnt       <= '0;
            rsp_valid <= 1'b1;
            rsp_data  <= cap_q;
          end
        end
        RUN: if (fall_en) begin
          if (cnt == len_q - 6'd1) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: behavioural TAP slave (IR capture 0001, bypass DR),
// TMS/TCK logging per command and a response scoreboard.
module tb_jtag_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = 2'b00;
  logic [5:0]  cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        TCK, TMS, TDI, TRST;
  logic        TDO = 1'b0;

  always #5 clk = ~clk;

  jtag_master #(.CLK_DIV(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .TCK       (TCK),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO),
    .TRST      (TRST)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- TAP slave model ----------------
  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SEL_DR, T_CAP_DR, T_SH_DR, T_EX1_DR, T_PA_DR, T_EX2_DR, T_UPD_DR,
    T_SEL_IR, T_CAP_IR, T_SH_IR, T_EX1_IR, T_PA_IR, T_EX2_IR, T_UPD_IR
  } tap_t;

  tap_t       tap_st = T_TLR;
  logic [3:0] ir = 4'hF;
  logic [3:0] ir_sh = '0;
  logic       byp = 1'b0;

  always @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      tap_st <= T_TLR;
      ir     <= 4'hF;
    end else begin
      case (tap_st)
        T_CAP_IR: ir_sh <= 4'b0001;
        T_SH_IR:  ir_sh <= {TDI, ir_sh[3:1]};
        T_UPD_IR: ir    <= ir_sh;
        T_CAP_DR: byp   <= 1'b0;
        T_SH_DR:  byp   <= TDI;
        default: ;
      endcase
      case (tap_st)
        T_TLR:    tap_st <= TMS ? T_TLR    : T_RTI;
        T_RTI:    tap_st <= TMS ? T_SEL_DR : T_RTI;
        T_SEL_DR: tap_st <= TMS ? T_SEL_IR : T_CAP_DR;
        T_CAP_DR: tap_st <= TMS ? T_EX1_DR : T_SH_DR;
        T_SH_DR:  tap_st <= TMS ? T_EX1_DR : T_SH_DR;
        T_EX1_DR: tap_st <= TMS ? T_UPD_DR : T_PA_DR;
        T_PA_DR:  tap_st <= TMS ? T_EX2_DR : T_PA_DR;
        T_EX2_DR: tap_st <= TMS ? T_UPD_DR : T_SH_DR;
        T_UPD_DR: tap_st <= TMS ? T_SEL_DR : T_RTI;
        T_SEL_IR: tap_st <= TMS ? T_TLR    : T_CAP_IR;
        T_CAP_IR: tap_st <= TMS ? T_EX1_IR : T_SH_IR;
        T_SH_IR:  tap_st <= TMS ? T_EX1_IR : T_SH_IR;
        T_EX1_IR: tap_st <= TMS ? T_UPD_IR : T_PA_IR;
        T_PA_IR:  tap_st <= TMS ? T_EX2_IR : T_PA_IR;
        T_EX2_IR: tap_st <= TMS ? T_UPD_IR : T_SH_IR;
        default:  tap_st <= TMS ? T_SEL_DR : T_RTI;
      endcase
    end
  end

  always @(negedge TCK)
    TDO <= (tap_st == T_SH_IR) ? ir_sh[0] : (tap_st == T_SH_DR) ? byp : 1'b0;

  // ---------------- TCK/TMS logging ----------------
  int unsigned cyc = 0;
  int unsigned last_rise = 0;
  int unsigned tck_n = 0;
  int unsigned period_bad = 0;
  logic [63:0] tms_log = '0;
  logic [63:0] trst_log = '0;

  always @(posedge clk) cyc++;

  always @(posedge TCK) begin
    if (tck_n < 64) begin
      tms_log[tck_n]  = TMS;
      trst_log[tck_n] = TRST;
    end
    if (tck_n > 0 && (cyc - last_rise) != 4) period_bad++;
    last_rise = cyc;
    tck_n++;
  end

  task automatic clear_log();
    tck_n      = 0;
    period_bad = 0;
    tms_log    = '0;
    trst_log   = '0;
  endtask

  // ---------------- response scoreboard ----------------
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      else check("rsp_data", 64'(rsp_data), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_ready(input string tag, input int unsigned budget);
    for (int unsigned i = 0; i < budget && !cmd_ready; i++) @(negedge clk);
    check({tag, "_ready"}, 64'(cmd_ready), 64'd1);
  endtask

  // Expected TMS per TCK from the IEEE 1149.1 walks starting in Run-Test/Idle
  task automatic expect_seq(input logic [1:0] typ, input int unsigned n,
                            output logic [63:0] v, output int unsigned k);
    v = '0;
    k = 0;
    case (typ)
      2'b00: begin
        for (int i = 0; i < 5; i++) begin v[k] = 1'b1; k++; end
        k++;
      end
      2'b01, 2'b10: begin
        v[0] = 1'b1; k = 1;
        if (typ == 2'b01) begin v[1] = 1'b1; k = 2; end
        k += 2 + (n - 1);
        v[k] = 1'b1; k++;
        v[k] = 1'b1; k++;
        k++;
      end
      default: k = n;
    endcase
  endtask

  task automatic do_cmd(input string tag, input logic [1:0] typ, input logic [5:0] len,
                        input int unsigned n, input logic [31:0] data, input logic [31:0] exp_rsp);
    logic [63:0] ev;
    int unsigned ek;
    wait_ready({tag, "_start"}, 20);
    clear_log();
    cmd_valid = 1'b1;
    cmd_type  = typ;
    cmd_len   = len;
    cmd_data  = data;
    if (typ == 2'b01 || typ == 2'b10) exp_q.push_back(exp_rsp);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_ready({tag, "_end"}, 400);
    expect_seq(typ, n, ev, ek);
    check({tag, "_tcks"}, 64'(tck_n), 64'(ek));
    check({tag, "_tms"}, tms_log, ev);
    check({tag, "_tap"}, 64'(tap_st), 64'(T_RTI));
    check({tag, "_period"}, 64'(period_bad), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int unsigned accepts;
    logic        busy_seen;

    repeat (3) @(negedge clk);
    check("rst_pins", 64'({TCK, TMS, TDI, TRST, cmd_ready, rsp_valid}), 64'(6'b010100));
    check("rst_rsp_data", 64'(rsp_data), 64'd0);

    clear_log();
    rst = 1'b0;
    wait_ready("por", 200);
    check("por_tcks", 64'(tck_n), 64'd6);
    check("por_tms", tms_log, 64'h1F);
    check("por_trst", trst_log, 64'h1F);
    check("por_tap", 64'(tap_st), 64'(T_RTI));
    check("por_period", 64'(period_bad), 64'd0);
    check("idle_tck", 64'(TCK), 64'd0);
    check("idle_tdi", 64'(TDI), 64'd0);

    do_cmd("ir_0001", 2'b01, 6'd4, 4, 32'h1, 32'h1);
    check("ir_0001_slave", 64'(ir), 64'h1);

    do_cmd("tap_rst", 2'b00, 6'd0, 0, 32'h0, 32'h0);
    check("tap_rst_trst", trst_log, 64'h1F);
    check("tap_rst_ir", 64'(ir), 64'hF);

    do_cmd("ir_bypass", 2'b01, 6'd4, 4, 32'hF, 32'h1);
    check("ir_bypass_slave", 64'(ir), 64'hF);

    do_cmd("dr_a5", 2'b10, 6'd32, 32, 32'hA5A5_A5A5, 32'h4B4B_4B4A);
    do_cmd("dr_len0", 2'b10, 6'd0, 32, 32'h8000_0001, 32'h0000_0002);
    do_cmd("dr_n1", 2'b10, 6'd1, 1, 32'h1, 32'h0);
    do_cmd("dr_n5", 2'b10, 6'd5, 5, 32'h15, 32'h0A);
    do_cmd("idle0", 2'b11, 6'd0, 0, 32'h0, 32'h0);
    do_cmd("idle3", 2'b11, 6'd3, 3, 32'h0, 32'h0);

    // Abort a DR shift during shift bit 10 (TCK index 13)
    wait_ready("abort_start", 20);
    clear_log();
    cmd_valid = 1'b1;
    cmd_type  = 2'b10;
    cmd_len   = 6'd32;
    cmd_data  = 32'hFFFF_FFFF;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int unsigned i = 0; i < 400 && tck_n < 14; i++) @(negedge clk);
    check("abort_at_bit10", 64'(tck_n), 64'd14);
    #1 rst = 1'b1;
    #1;
    check("abort_pins", 64'({TCK, TMS, TDI, TRST, cmd_ready, rsp_valid}), 64'(6'b010100));
    check("abort_rsp_data", 64'(rsp_data), 64'd0);
    repeat (3) @(negedge clk);
    clear_log();
    rst = 1'b0;
    wait_ready("abort_reseq", 200);
    check("abort_reseq_tcks", 64'(tck_n), 64'd6);
    check("abort_reseq_tms", tms_log, 64'h1F);
    check("abort_reseq_trst", trst_log, 64'h1F);
    check("abort_reseq_tap", 64'(tap_st), 64'(T_RTI));

    // cmd_valid held high through the whole command, cmd_len 40 -> 32 bits
    wait_ready("hold_start", 20);
    clear_log();
    accepts   = 0;
    busy_seen = 1'b0;
    cmd_type  = 2'b10;
    cmd_len   = 6'd40;
    cmd_data  = 32'h1234_5678;
    exp_q.push_back(32'h2468_ACF0);
    cmd_valid = 1'b1;
    for (int unsigned i = 0; i < 400; i++) begin
      if (cmd_ready && busy_seen) break;
      if (!cmd_ready) busy_seen = 1'b1;
      if (cmd_valid && cmd_ready) accepts++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("hold_ready", 64'(cmd_ready), 64'd1);
    check("hold_accepts", 64'(accepts), 64'd1);
    check("hold_tcks", 64'(tck_n), 64'd37);
    check("hold_tap", 64'(tap_st), 64'(T_RTI));

    repeat (4) @(negedge clk);
    check("end_tdi", 64'(TDI), 64'd0);
    check("end_tck", 64'(TCK), 64'd0);
    check("rsp_pending", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
